// File: rtl/a1335_angle_tracker.sv
// Polls the A1335 angle reader at a fixed rate and unwraps the 12-bit absolute
// angle into a signed 32-bit multi-turn position and a per-sample velocity.
module a1335_angle_tracker #(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int UPDATE_FREQ    = 1000,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        zero_request,
  output logic        read_angle,
  input  logic        done,
  input  logic [11:0] angle,
  input  logic        ack_error,
  output logic [31:0] position,
  output logic [15:0] velocity,
  output logic        sample_valid,
  output logic [31:0] sample_count,
  output logic [15:0] error_count,
  output logic        timeout
);

  localparam int PERIOD = CLOCK_FREQ / UPDATE_FREQ;
  localparam int PW     = $clog2(PERIOD);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, TRIGGER, WAIT_BUSY, WAIT_DONE, UPDATE, ERROR
  } state_t;

  state_t        state, next_state;
  logic [PW-1:0] period_cnt;
  logic          tick_pending;
  logic          tick_clear;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic [11:0]   angle_lat;
  logic          ack_lat;
  logic [11:0]   prev_angle;
  logic [11:0]   delta;
  logic          first;
  logic          zero_pending;
  logic          enable_d;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES));
  assign delta   = angle_lat - prev_angle;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    read_angle = 1'b0;
    tick_clear = 1'b0;
    case (state)
      IDLE: begin
        if (enable && tick_pending && done) begin
          next_state = TRIGGER;
          tick_clear = 1'b1;
        end
      end
      TRIGGER: begin
        read_angle = 1'b1;
        next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!done)        next_state = WAIT_DONE;
        else if (tmo_hit) next_state = ERROR;
      end
      WAIT_DONE: begin
        if (done)         next_state = UPDATE;
        else if (tmo_hit) next_state = ERROR;
      end
      UPDATE:  next_state = IDLE;
      ERROR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A tick arriving while one is still pending is simply absorbed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt   <= '0;
      tick_pending <= 1'b0;
    end else if (!enable) begin
      period_cnt   <= '0;
      tick_pending <= 1'b0;
    end else if (period_cnt == PW'(PERIOD - 1)) begin
      period_cnt   <= '0;
      tick_pending <= 1'b1;
    end else begin
      period_cnt <= period_cnt + 1'b1;
      if (tick_clear) tick_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == TRIGGER || (state == WAIT_BUSY && !done)) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Reader data is captured on the done edge so later changes cannot corrupt it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      angle_lat <= '0;
      ack_lat   <= 1'b0;
    end else if (state == WAIT_DONE && done) begin
      angle_lat <= angle;
      ack_lat   <= ack_error;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      position     <= '0;
      velocity     <= '0;
      sample_valid <= 1'b0;
      sample_count <= '0;
      error_count  <= '0;
      timeout      <= 1'b0;
      prev_angle   <= '0;
      first        <= 1'b1;
      zero_pending <= 1'b0;
      enable_d     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      enable_d     <= enable;
      if (zero_request) zero_pending <= 1'b1;

      if (state == UPDATE) begin
        if (ack_lat) begin
          if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        end else begin
          prev_angle   <= angle_lat;
          sample_count <= sample_count + 32'd1;
          sample_valid <= 1'b1;
          if (first) begin
            position <= '0;
            velocity <= '0;
            first    <= 1'b0;
          end else if (zero_pending || zero_request) begin
            position     <= '0;
            velocity     <= {{4{delta[11]}}, delta};
            zero_pending <= 1'b0;
          end else begin
            position <= position + {{20{delta[11]}}, delta};
            velocity <= {{4{delta[11]}}, delta};
          end
        end
      end

      if (state == ERROR) begin
        timeout <= 1'b1;
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
      end

      // Re-enabling restarts unwrapping so no turn is counted across the gap.
      if (enable && !enable_d) first <= 1'b1;
    end
  end

endmodule

// File: tb/tb_a1335_angle_tracker.sv
// Self-checking bench for a1335_angle_tracker: a reader model answers requests
// and a turn-unwrapping reference model predicts every accepted sample.
module tb_a1335_angle_tracker;

  localparam int READ_LAT = 3;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        zero_request;
  logic        read_angle;
  logic        done;
  logic [11:0] angle;
  logic        ack_error;
  logic [31:0] position;
  logic [15:0] velocity;
  logic        sample_valid;
  logic [31:0] sample_count;
  logic [15:0] error_count;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_req = -1;
  bit check_period = 0;

  logic [11:0] rd_angle = '0;
  bit          rd_ack = 0;
  bit          rd_stuck = 0;

  int m_pos, m_vel, m_prev, m_count, m_err;
  bit m_first, m_zero, m_tmo;

  a1335_angle_tracker #(
    .CLOCK_FREQ(1000),
    .UPDATE_FREQ(10),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .zero_request(zero_request),
    .read_angle(read_angle),
    .done(done),
    .angle(angle),
    .ack_error(ack_error),
    .position(position),
    .velocity(velocity),
    .sample_valid(sample_valid),
    .sample_count(sample_count),
    .error_count(error_count),
    .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reader: drops done two cycles after a request, returns the angle later.
  initial begin
    done = 1'b1;
    angle = '0;
    ack_error = 1'b0;
    forever begin
      @(negedge clock);
      if (read_angle && !rd_stuck) begin
        repeat (2) @(negedge clock);
        done = 1'b0;
        repeat (READ_LAT) @(negedge clock);
        angle = rd_angle;
        ack_error = rd_ack;
        done = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic modelSample(input int a, input bit ack);
    int d;
    if (ack) begin
      if (m_err < 65535) m_err++;
      return;
    end
    d = (a - m_prev) & 4095;
    if (d >= 2048) d = d - 4096;
    if (m_first) begin
      m_pos = 0;
      m_vel = 0;
      m_first = 0;
    end else if (m_zero) begin
      m_pos = 0;
      m_vel = d;
      m_zero = 0;
    end else begin
      m_pos = m_pos + d;
      m_vel = d;
    end
    m_prev = a;
    m_count++;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    enable = 1'b0;
    zero_request = 1'b0;
    rd_stuck = 0;
    rd_ack = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    m_pos = 0; m_vel = 0; m_prev = 0; m_count = 0; m_err = 0;
    m_first = 1; m_zero = 0; m_tmo = 0;
    last_req = -1;
    @(negedge clock);
    checkOutput("rst_position", position, 32'h0);
    checkOutput("rst_velocity", {16'h0, velocity}, 32'h0);
    checkOutput("rst_count", sample_count, 32'h0);
    checkOutput("rst_errors", {16'h0, error_count}, 32'h0);
    checkOutput("rst_flags", {29'h0, timeout, sample_valid, read_angle}, 32'h0);
    enable = 1'b1;
  endtask

  task automatic applyStimulus(input int a, input bit ack, input bit zero,
                               input bit stuck, input bit drop_en);
    bit got;
    rd_angle = 12'(a);
    rd_ack = ack;
    rd_stuck = stuck;
    if (zero) begin
      zero_request = 1'b1;
      @(negedge clock);
      zero_request = 1'b0;
      m_zero = 1;
    end
    got = 0;
    for (int i = 0; i < 250 && !got; i++) begin
      @(negedge clock);
      if (read_angle) got = 1;
    end
    checkOutput("read_request", {31'h0, got}, 32'h1);
    if (!got) return;
    if (check_period && last_req >= 0) checkOutput("poll_period", cyc - last_req, 32'd100);
    last_req = cyc;
    if (drop_en) enable = 1'b0;

    if (stuck) begin
      repeat (50) @(negedge clock);
      checkOutput("timeout_early", {31'h0, timeout}, 32'h0);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clock);
        if (timeout) got = 1;
      end
      if (m_err < 65535) m_err++;
      m_tmo = 1;
      checkOutput("timeout_set", {31'h0, timeout}, {31'h0, m_tmo});
      checkOutput("timeout_errors", {16'h0, error_count}, 32'(m_err));
      rd_stuck = 0;
    end else if (ack) begin
      repeat (15) @(negedge clock);
      modelSample(a, 1);
      checkOutput("nack_errors", {16'h0, error_count}, 32'(m_err));
      checkOutput("nack_count", sample_count, 32'(m_count));
    end else begin
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clock);
        if (sample_valid) got = 1;
      end
      checkOutput("sample_valid", {31'h0, got}, 32'h1);
      modelSample(a, 0);
      checkOutput("position", position, 32'(m_pos));
      checkOutput("velocity", {16'h0, velocity}, {16'h0, 16'(m_vel)});
      checkOutput("sample_count", sample_count, 32'(m_count));
      checkOutput("error_count", {16'h0, error_count}, 32'(m_err));
      @(negedge clock);
      checkOutput("valid_pulse", {31'h0, sample_valid}, 32'h0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    zero_request = 1'b0;

    $display("[TB] basic sequence 100,300,200");
    doReset();
    check_period = 1;
    applyStimulus(100, 0, 0, 0, 0);
    applyStimulus(300, 0, 0, 0, 0);
    applyStimulus(200, 0, 0, 0, 0);
    check_period = 0;
    checkOutput("basic_pos_literal", position, 32'd100);

    $display("[TB] wrap 4000,50,4000");
    doReset();
    applyStimulus(4000, 0, 0, 0, 0);
    applyStimulus(50, 0, 0, 0, 0);
    checkOutput("wrap_pos_literal", position, 32'd146);
    applyStimulus(4000, 0, 0, 0, 0);

    $display("[TB] half turn");
    doReset();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(2048, 0, 0, 0, 0);
    checkOutput("half_pos_literal", position, 32'hFFFFF800);

    $display("[TB] nack on second read");
    doReset();
    applyStimulus(100, 0, 0, 0, 0);
    applyStimulus(500, 1, 0, 0, 0);
    applyStimulus(300, 0, 0, 0, 0);
    checkOutput("nack_pos_literal", position, 32'd200);

    $display("[TB] reader stuck");
    doReset();
    applyStimulus(100, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(150, 0, 0, 0, 0);

    $display("[TB] zero request and enable toggle");
    doReset();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(500, 0, 0, 0, 0);
    applyStimulus(510, 0, 1, 0, 0);
    applyStimulus(510, 0, 0, 0, 1);
    repeat (20) @(negedge clock);
    enable = 1'b1;
    m_first = 1;
    applyStimulus(700, 0, 0, 0, 0);

    $display("[TB] random transactions");
    doReset();
    for (int n = 0; n < 40; n++) begin
      applyStimulus(int'($urandom_range(0, 4095)), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 7) == 0), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
